// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the ID/IX boundary: load-use stalls,
// multi-cycle multiply occupancy of IX, taken-branch flushes and a stall counter.
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES  = 4,
    parameter int FLUSH_SLOTS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_rs_used,
    input  logic        id_rt_used,
    input  logic        ix_valid,
    input  logic [4:0]  ix_rd,
    input  logic        ix_is_load,
    input  logic        ix_is_mul,
    input  logic        ix_branch_taken,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        flush_if_id,
    output logic        id_ix_en,
    output logic        id_ix_bubble,
    output logic [1:0]  ctrl_state,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MUL   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_NORMAL,
        ACT_MUL_STALL,
        ACT_LOAD_USE,
        ACT_SQUASH
    } action_t;

    localparam logic [3:0] MUL_INIT    = 4'(MUL_CYCLES - 1);
    localparam logic [2:0] FLUSH_INIT  = 3'(FLUSH_SLOTS - 1);
    localparam bit         FLUSH_MULTI = (FLUSH_SLOTS > 1);
    localparam logic [15:0] STALL_MAX  = 16'hFFFF;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  mul_cnt;
    logic [3:0]  mul_cnt_nxt;
    logic [2:0]  flush_cnt;
    logic [2:0]  flush_cnt_nxt;
    action_t     action;

    logic        rs_hit;
    logic        rt_hit;
    logic        load_use;
    logic        branch_hit;
    logic        mul_hit;

    // Hazard detection; a load targeting r0 never creates a dependency.
    always_comb begin
        rs_hit     = id_rs_used && (id_rs == ix_rd);
        rt_hit     = id_rt_used && (id_rt == ix_rd);
        load_use   = ix_valid && ix_is_load && (ix_rd != 5'd0) && id_valid && (rs_hit || rt_hit);
        branch_hit = ix_valid && ix_branch_taken;
        mul_hit    = ix_valid && ix_is_mul;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            mul_cnt   <= 4'd0;
            flush_cnt <= 3'd0;
        end else begin
            state     <= state_nxt;
            mul_cnt   <= mul_cnt_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // In RUN a taken branch outranks a multiply; MUL and FLUSH ignore IX hazards.
    always_comb begin
        state_nxt     = state;
        mul_cnt_nxt   = mul_cnt;
        flush_cnt_nxt = flush_cnt;
        unique case (state)
            ST_RUN: begin
                if (branch_hit) begin
                    if (FLUSH_MULTI) begin
                        state_nxt     = ST_FLUSH;
                        flush_cnt_nxt = FLUSH_INIT;
                    end
                end else if (mul_hit) begin
                    state_nxt   = ST_MUL;
                    mul_cnt_nxt = MUL_INIT;
                end
            end
            ST_MUL: begin
                if (mul_cnt <= 4'd1) begin
                    state_nxt   = ST_RUN;
                    mul_cnt_nxt = 4'd0;
                end else begin
                    mul_cnt_nxt = mul_cnt - 4'd1;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt <= 3'd1) begin
                    state_nxt     = ST_RUN;
                    flush_cnt_nxt = 3'd0;
                end else begin
                    flush_cnt_nxt = flush_cnt - 3'd1;
                end
            end
            default: begin
                state_nxt     = ST_RUN;
                mul_cnt_nxt   = 4'd0;
                flush_cnt_nxt = 3'd0;
            end
        endcase
    end

    always_comb begin
        action = ACT_NORMAL;
        if (rst) begin
            action = ACT_RESET;
        end else begin
            unique case (state)
                ST_MUL:   action = ACT_MUL_STALL;
                ST_FLUSH: action = ACT_SQUASH;
                default: begin
                    if (branch_hit)    action = ACT_SQUASH;
                    else if (mul_hit)  action = ACT_MUL_STALL;
                    else if (load_use) action = ACT_LOAD_USE;
                    else               action = ACT_NORMAL;
                end
            endcase
        end
    end

    // Enables are combinational because the pipeline registers latch on negedge.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        flush_if_id  = 1'b0;
        id_ix_en     = 1'b1;
        id_ix_bubble = 1'b0;
        unique case (action)
            ACT_RESET: begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                flush_if_id  = 1'b1;
                id_ix_bubble = 1'b1;
            end
            ACT_MUL_STALL: begin
                pc_en    = 1'b0;
                if_id_en = 1'b0;
                id_ix_en = 1'b0;
            end
            ACT_LOAD_USE: begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ix_bubble = 1'b1;
            end
            ACT_SQUASH: begin
                flush_if_id  = 1'b1;
                id_ix_bubble = 1'b1;
            end
            default: begin
                pc_en = 1'b1;
            end
        endcase
    end

    assign ctrl_state = rst ? 2'd0 : state;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (!pc_en && (stall_cnt != STALL_MAX)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall controller that sequences the ID/IX pipeline register and the upstream PC and IF/ID stages. Each cycle it decides whether the front end advances, holds, or is squashed, and whether ID/IX captures the decoded instruction or a bubble. It covers three hazards: load-use stalls, multi-cycle multiply occupancy of IX, and taken-branch flushes. It also keeps a saturating stall-cycle performance counter.

## Interface
- MUL_CYCLES, 4: cycles a multiply occupies IX. Legal range is 2..15.
- FLUSH_SLOTS, 2: younger instruction slots squashed after a taken branch, counting the detection cycle. Legal range is 1..7.
- clk  in  1  system clock; state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs, id_rt  in  5 each  source register numbers in ID.
- id_rs_used, id_rt_used  in  1 each  the corresponding source is actually read.
- ix_valid  in  1  IX holds a valid, non-bubble instruction.
- ix_rd  in  5  destination register of the IX instruction.
- ix_is_load  in  1  the IX instruction is a load.
- ix_is_mul  in  1  the IX instruction is a multi-cycle multiply.
- ix_branch_taken  in  1  IX resolved a taken branch.
- pc_en  out  1  PC may update.
- if_id_en  out  1  IF/ID may capture.
- flush_if_id  out  1  IF/ID loads a NOP.
- id_ix_en  out  1  ID/IX captures on its next latch edge.
- id_ix_bubble  out  1  ID/IX loads a NOP (IR=0, is_branch=0) instead of ID data.
- ctrl_state  out  2  current state: 0 RUN, 1 MUL, 2 FLUSH.
- stall_cnt  out  16  saturating count of cycles with pc_en=0, excluding reset.

## Operation
- States are RUN, MUL and FLUSH, held with a 4-bit `mul_cnt` and a 3-bit `flush_cnt`.
- Outputs are combinational from the registered state and the current inputs. The pipeline registers latch on negedge, so a decision takes effect in the same cycle.
- A load-use hazard exists when all of the following hold:
  - ix_valid and ix_is_load are high.
  - ix_rd != 0.
  - id_valid is high.
  - (id_rs_used and id_rs==ix_rd) or (id_rt_used and id_rt==ix_rd).
- In RUN, priority is branch, then mul, then load-use, then normal:
  - **Branch** (ix_valid and ix_branch_taken): pc_en=1, if_id_en=1, flush_if_id=1, id_ix_en=1, id_ix_bubble=1. If FLUSH_SLOTS>1, go to FLUSH with flush_cnt=FLUSH_SLOTS-1; otherwise stay in RUN.
  - **Mul** (ix_valid and ix_is_mul): pc_en=0, if_id_en=0, id_ix_en=0. Go to MUL with mul_cnt=MUL_CYCLES-1.
  - **Load-use**: pc_en=0, if_id_en=0, id_ix_en=1, id_ix_bubble=1. Stay in RUN; the hazard clears once the bubble advances.
  - **Normal**: pc_en=1, if_id_en=1, id_ix_en=1, bubble=0, flush=0.
- In MUL: outputs are the same as the Mul case. ix_branch_taken and load-use are ignored. Decrement mul_cnt each cycle; when mul_cnt==1, return to RUN. The multiply stalls the front end for exactly MUL_CYCLES-1 cycles after the detection cycle.
- In FLUSH: pc_en=1, if_id_en=1, flush_if_id=1, id_ix_en=1, id_ix_bubble=1. ix_branch_taken is ignored because IX holds a squashed slot. Decrement flush_cnt; when flush_cnt==1, return to RUN.
- stall_cnt increments on each posedge where rst=0 and pc_en=0. It saturates at 16'hFFFF.

## Timing
- rst is sampled on posedge. While rst=1, outputs are driven combinationally:
  - pc_en=0, if_id_en=0, flush_if_id=1.
  - id_ix_en=1, id_ix_bubble=1.
  - ctrl_state=0.
- The cycle after reset deasserts: state is RUN, mul_cnt=0, flush_cnt=0, stall_cnt=0.
- Reset asserted mid-MUL or mid-FLUSH aborts the sequence. The next cycle is RUN with counters cleared.
- There is no latency between hazard inputs and enables: the response is combinational in the same cycle.
- A state change is visible on ctrl_state one cycle after the detection cycle.
- If branch and mul are both asserted in the same IX cycle, branch wins.
- If a load-use hazard and a taken branch occur together, branch wins and the stalled ID instruction is squashed.
- A load to r0 never stalls.
- If only a source with its used-bit at 0 matches, the block does not stall.

## Test plan
- **Reset:** hold rst for 3 cycles → pc_en=0, flush_if_id=1, id_ix_bubble=1. After release: ctrl_state=0, stall_cnt=0.
- **Load-use:** ix_is_load=1, ix_rd=5, id_rs=5, id_rs_used=1 for one cycle → pc_en=0, id_ix_bubble=1, stall_cnt=1. The next cycle, with ix_valid=0, is a normal advance. Repeat with ix_rd=0 → no stall.
- **Multiply:** ix_is_mul=1 with MUL_CYCLES=4 → pc_en=0 for 4 consecutive cycles (detection plus 3 in MUL), then RUN with stall_cnt=4. A branch_taken pulse during MUL is ignored.
- **Branch flush:** ix_branch_taken=1 with FLUSH_SLOTS=2 → flush_if_id and id_ix_bubble are high for 2 cycles, pc_en stays 1, stall_cnt is unchanged.
- **Priority and abort:** branch, mul and load-use asserted together → branch behaviour only. In a separate run, assert rst during MUL with mul_cnt=2 → RUN on the next cycle, mul_cnt=0.
- **Saturation:** hold a load-use hazard for 70000 cycles → stall_cnt=16'hFFFF and it does not wrap.
